jk_bank_driver: RTL and testbench

Command-side controller for a bank of JK flip-flops. It accepts target words over a valid/ready handshake and tracks the bank's expected state in a shadow register. For each word it computes the per-bit J/K excitation (or a clear) and drives the bank for exactly one clock. On the following cycle it reads `q`/`nq` back and flags any bit that did not land. It sits between a register-write source and a `WIDTH`-wide array of JK flops with synchronous active-high clear.

---
 rtl/jk_bank_driver.sv | 141 ++++++++++++++
 tb/tb_jk_bank_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_driver.sv
// Command-side driver for a WIDTH-wide bank of JK flops: computes excitation
// from a shadow copy of the bank, drives it for one clock, then verifies readback.

module jk_bank_lane #(
  parameter int USE_TOGGLE = 0
) (
  input  logic d,
  input  logic s,
  input  logic clr,
  input  logic e,
  input  logic q,
  input  logic nq,
  output logic j,
  output logic k,
  output logic bad
);
  logic c;

  assign c   = d ^ s;
  assign j   = clr ? 1'b0 : ((USE_TOGGLE != 0) ? c : (c & d));
  assign k   = clr ? 1'b0 : ((USE_TOGGLE != 0) ? c : (c & ~d));
  // a bit is bad if it landed wrong or the flop's complementary outputs disagree
  assign bad = (e ^ q) | ~(q ^ nq);
endmodule

module jk_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             cl_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_clr,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_cl,
  input  logic [WIDTH-1:0] jk_q,
  input  logic [WIDTH-1:0] jk_nq,
  output logic [WIDTH-1:0] shadow,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);
  typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] expected, exp_d;
  logic             init_cmd, init_d;
  logic [WIDTH-1:0] j_d, k_d, mask_d, shadow_d;
  logic             cl_d, ready_d, done_d, err_d;
  logic [WIDTH-1:0] exc_j, exc_k, bad;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    jk_bank_lane #(.USE_TOGGLE(USE_TOGGLE)) u_lane (
      .d   (in_data[g]),
      .s   (shadow[g]),
      .clr (in_clr),
      .e   (expected[g]),
      .q   (jk_q[g]),
      .nq  (jk_nq[g]),
      .j   (exc_j[g]),
      .k   (exc_k[g]),
      .bad (bad[g])
    );
  end

  always_comb begin
    state_d  = state;
    j_d      = '0;
    k_d      = '0;
    cl_d     = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mask_d   = err_mask;
    shadow_d = shadow;
    exp_d    = expected;
    init_d   = init_cmd;
    case (state)
      INIT: begin
        cl_d    = 1'b1;
        exp_d   = '0;
        init_d  = 1'b1;
        state_d = DRIVE;
      end
      IDLE: begin
        ready_d = 1'b1;
        if (in_valid && in_ready) begin
          ready_d = 1'b0;
          j_d     = exc_j;
          k_d     = exc_k;
          cl_d    = in_clr;
          exp_d   = in_clr ? '0 : in_data;
          init_d  = 1'b0;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        mask_d   = bad;
        err_d    = |bad;
        // resync to the real bank so a stuck bit is re-driven next time
        shadow_d = jk_q;
        done_d   = ~init_cmd;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge cl_n) begin
    if (!cl_n) begin
      state    <= INIT;
      jk_j     <= '0;
      jk_k     <= '0;
      jk_cl    <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
      shadow   <= '0;
      expected <= '0;
      init_cmd <= 1'b0;
    end else begin
      state    <= state_d;
      jk_j     <= j_d;
      jk_k     <= k_d;
      jk_cl    <= cl_d;
      in_ready <= ready_d;
      done     <= done_d;
      err      <= err_d;
      err_mask <= mask_d;
      shadow   <= shadow_d;
      expected <= exp_d;
      init_cmd <= init_d;
    end
  end
endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench: two drivers (set/reset and toggle excitation) each on a modelled JK bank,
// checked every cycle against a transaction-timing model plus literal pins.

module tb_jk_bank_driver;
  logic clk = 1'b0;
  logic cl_n;
  logic en = 1'b0;

  logic       vld [2];
  logic [7:0] din [2];
  logic       clr [2];
  logic       rdy [2];
  logic [7:0] jj  [2];
  logic [7:0] kk  [2];
  logic       cl  [2];
  logic [7:0] sh  [2];
  logic [7:0] msk [2];
  logic       dn  [2];
  logic       er  [2];
  logic [7:0] bq  [2] = '{8'h3C, 8'hC3};
  logic [7:0] bnq [2];
  logic [7:0] stuck [2] = '{8'h00, 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(8), .USE_TOGGLE(0)) u0 (
    .clk(clk), .cl_n(cl_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(din[0]),
    .in_clr(clr[0]), .jk_j(jj[0]), .jk_k(kk[0]), .jk_cl(cl[0]), .jk_q(bq[0]),
    .jk_nq(bnq[0]), .shadow(sh[0]), .done(dn[0]), .err(er[0]), .err_mask(msk[0]));

  jk_bank_driver #(.WIDTH(8), .USE_TOGGLE(1)) u1 (
    .clk(clk), .cl_n(cl_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(din[1]),
    .in_clr(clr[1]), .jk_j(jj[1]), .jk_k(kk[1]), .jk_cl(cl[1]), .jk_q(bq[1]),
    .jk_nq(bnq[1]), .shadow(sh[1]), .done(dn[1]), .err(er[1]), .err_mask(msk[1]));

  // JK bank with sync clear; stuck-at-0 bits injected through 'stuck'
  assign bnq[0] = ~bq[0];
  assign bnq[1] = ~bq[1];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      bq[i] <= (cl[i] ? 8'h00 : ((jj[i] & ~bq[i]) | (~kk[i] & bq[i]))) & ~stuck[i];
  end

  // Model: outputs follow from the edge count since the last accepted command
  int         ec;
  int         t0 [2];
  bit         initc [2];
  logic [7:0] xp [2];
  logic [7:0] e_j [2], e_k [2], e_sh [2], e_msk [2];
  bit         e_cl [2], e_rdy [2], e_dn [2], e_er [2];

  always @(posedge clk or negedge cl_n) begin
    if (!cl_n) begin
      ec = 0;
      for (int i = 0; i < 2; i++) begin
        t0[i] = -10; initc[i] = 1'b0; xp[i] = 8'h00;
        e_j[i] = 8'h00; e_k[i] = 8'h00; e_sh[i] = 8'h00; e_msk[i] = 8'h00;
        e_cl[i] = 1'b0; e_rdy[i] = 1'b0; e_dn[i] = 1'b0; e_er[i] = 1'b0;
      end
    end else begin
      ec = ec + 1;
      for (int i = 0; i < 2; i++) begin
        int d;
        d = ec - t0[i];
        if (ec == 1) begin
          e_cl[i] = 1'b1; xp[i] = 8'h00; initc[i] = 1'b1; t0[i] = 1;
        end else if (d == 1) begin
          e_j[i] = 8'h00; e_k[i] = 8'h00; e_cl[i] = 1'b0;
        end else if (d == 2) begin
          e_msk[i] = (xp[i] ^ bq[i]) | ~(bq[i] ^ bnq[i]);
          e_er[i]  = (e_msk[i] != 8'h00);
          e_sh[i]  = bq[i];
          e_dn[i]  = !initc[i];
          e_rdy[i] = 1'b1;
        end else if (d >= 3) begin
          e_dn[i] = 1'b0; e_er[i] = 1'b0;
          if (vld[i]) begin
            t0[i] = ec; e_rdy[i] = 1'b0; initc[i] = 1'b0;
            e_j[i] = 8'h00; e_k[i] = 8'h00;
            if (clr[i]) begin
              e_cl[i] = 1'b1; xp[i] = 8'h00;
            end else begin
              xp[i] = din[i];
              for (int b = 0; b < 8; b++) begin
                if (din[i][b] != e_sh[i][b]) begin
                  if (i == 1) begin
                    e_j[i][b] = 1'b1; e_k[i][b] = 1'b1;
                  end else if (din[i][b]) e_j[i][b] = 1'b1;
                  else e_k[i][b] = 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input logic [7:0] act, input logic [7:0] mdl,
                     input logic [7:0] lit);
    chk(nm, act, lit);
    chk({nm, " model"}, mdl, lit);
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d jk_j", i), jj[i], e_j[i]);
        chk($sformatf("u%0d jk_k", i), kk[i], e_k[i]);
        chk($sformatf("u%0d jk_cl", i), 8'(cl[i]), 8'(e_cl[i]));
        chk($sformatf("u%0d in_ready", i), 8'(rdy[i]), 8'(e_rdy[i]));
        chk($sformatf("u%0d done", i), 8'(dn[i]), 8'(e_dn[i]));
        chk($sformatf("u%0d err", i), 8'(er[i]), 8'(e_er[i]));
        chk($sformatf("u%0d err_mask", i), msk[i], e_msk[i]);
        chk($sformatf("u%0d shadow", i), sh[i], e_sh[i]);
      end
    end
  end

  // Holds valid until the model sees the handshake; returns 1 time unit after it
  task automatic send(input int i, input logic [7:0] dat, input logic c);
    bit ok;
    ok = 1'b0;
    vld[i] = 1'b1; din[i] = dat; clr[i] = c;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #1;
      if (t0[i] == ec) ok = 1'b1;
    end
    vld[i] = 1'b0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL u%0d accept timeout data %h", i, dat);
    end
  endtask

  task automatic wait2();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; din[i] = 8'h00; clr[i] = 1'b0;
    end
    cl_n = 1'b1;
    #2 cl_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    #2 cl_n = 1'b1;

    @(posedge clk); #1;
    pin("init jk_cl", 8'(cl[0]), 8'(e_cl[0]), 8'h01);
    pin("init ready", 8'(rdy[1]), 8'(e_rdy[1]), 8'h00);
    @(posedge clk); #1;
    pin("init cl drop", 8'(cl[1]), 8'(e_cl[1]), 8'h00);
    @(posedge clk); #1;
    pin("init ready up", 8'(rdy[0]), 8'(e_rdy[0]), 8'h01);
    pin("init shadow", sh[1], e_sh[1], 8'h00);
    pin("init no done", 8'(dn[0]), 8'(e_dn[0]), 8'h00);

    send(0, 8'hA5, 1'b0);
    pin("A5 j", jj[0], e_j[0], 8'hA5);
    pin("A5 k", kk[0], e_k[0], 8'h00);
    wait2();
    pin("A5 done", 8'(dn[0]), 8'(e_dn[0]), 8'h01);
    pin("A5 shadow", sh[0], e_sh[0], 8'hA5);
    pin("A5 err", 8'(er[0]), 8'(e_er[0]), 8'h00);

    send(0, 8'h5A, 1'b0);
    pin("5A j", jj[0], e_j[0], 8'h5A);
    pin("5A k", kk[0], e_k[0], 8'hA5);
    wait2();

    send(0, 8'h3C, 1'b0);
    wait2();
    pin("3C shadow", sh[0], e_sh[0], 8'h3C);
    send(0, 8'h77, 1'b1);
    pin("clr cl", 8'(cl[0]), 8'(e_cl[0]), 8'h01);
    pin("clr j", jj[0], e_j[0], 8'h00);
    pin("clr k", kk[0], e_k[0], 8'h00);
    wait2();
    pin("clr shadow", sh[0], e_sh[0], 8'h00);
    pin("clr done", 8'(dn[0]), 8'(e_dn[0]), 8'h01);

    send(0, 8'h00, 1'b0);
    pin("same j", jj[0], e_j[0], 8'h00);
    wait2();
    pin("same done", 8'(dn[0]), 8'(e_dn[0]), 8'h01);

    stuck[0] = 8'h04;
    send(0, 8'h04, 1'b0);
    pin("stuck j", jj[0], e_j[0], 8'h04);
    wait2();
    pin("stuck err", 8'(er[0]), 8'(e_er[0]), 8'h01);
    pin("stuck mask", msk[0], e_msk[0], 8'h04);
    pin("stuck shadow", sh[0], e_sh[0], 8'h00);
    pin("stuck done", 8'(dn[0]), 8'(e_dn[0]), 8'h01);
    send(0, 8'h04, 1'b0);
    pin("stuck redrive j", jj[0], e_j[0], 8'h04);
    wait2();
    stuck[0] = 8'h00;

    send(1, 8'hFF, 1'b0);
    pin("tog FF j", jj[1], e_j[1], 8'hFF);
    pin("tog FF k", kk[1], e_k[1], 8'hFF);
    send(1, 8'h0F, 1'b0);
    pin("tog 0F j", jj[1], e_j[1], 8'hF0);
    pin("tog 0F k", kk[1], e_k[1], 8'hF0);
    wait2();
    pin("tog shadow", sh[1], e_sh[1], 8'h0F);
    pin("tog done", 8'(dn[1]), 8'(e_dn[1]), 8'h01);

    send(0, 8'hAA, 1'b0);
    pin("rst drive j", jj[0], e_j[0], 8'hAA);
    #1 cl_n = 1'b0;
    #1;
    pin("rst async j", jj[0], e_j[0], 8'h00);
    pin("rst async k", kk[0], e_k[0], 8'h00);
    repeat (2) @(negedge clk);
    #2 cl_n = 1'b1;
    @(posedge clk); #1;
    pin("reinit cl", 8'(cl[0]), 8'(e_cl[0]), 8'h01);
    pin("reinit no done", 8'(dn[0]), 8'(e_dn[0]), 8'h00);
    wait2();
    pin("reinit ready", 8'(rdy[0]), 8'(e_rdy[0]), 8'h01);
    pin("reinit no done2", 8'(dn[0]), 8'(e_dn[0]), 8'h00);
    pin("reinit shadow", sh[0], e_sh[0], 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
